// File: rtl/nes_joypad_bridge.sv
// Avalon-MM bridge that lets the NIOS publish two NES pad states and presents them
// to the NES core as a pair of 4021-style serial shift registers at $4016/$4017.
module nes_joypad_bridge #(
    parameter bit          FILL_BIT = 1'b1,
    parameter int          COUNT_W  = 16,
    parameter logic [31:0] ID_VALUE = 32'h4E455331
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [1:0]  slave_address,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    input  logic        nes_strobe_we,
    input  logic        nes_strobe_d,
    input  logic [1:0]  nes_rd_en,
    output logic [1:0]  nes_rd_data
);

    localparam logic [1:0] ADDR_BUTTONS = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_ID      = 2'd3;

    logic [15:0]        buttons_q, buttons_d;
    logic               enable_q, enable_d;
    logic               strobe_q, strobe_d;
    logic [1:0][7:0]    shift_q, shift_d;
    logic [1:0][3:0]    idx_q, idx_d;
    logic [COUNT_W-1:0] poll_q, poll_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         nes_rd_q, nes_rd_d;

    logic        wr_buttons;
    logic        wr_control;
    logic        reload;
    logic        strobe_fall;
    logic [31:0] status;
    logic [31:0] reg_mux;

    function automatic logic [3:0] idx_inc(input logic [3:0] idx);
        return (idx >= 4'd8) ? 4'd8 : idx + 4'd1;
    endfunction

    assign wr_buttons  = slave_write && (slave_address == ADDR_BUTTONS);
    assign wr_control  = slave_write && (slave_address == ADDR_CONTROL);
    // A rising strobe write reloads on the same edge, so a coincident read
    // sees the old shift bit and its shift is discarded.
    assign reload      = strobe_q || (nes_strobe_we && nes_strobe_d);
    assign strobe_fall = strobe_q && nes_strobe_we && !nes_strobe_d;

    always_comb begin
        status                = '0;
        status[COUNT_W-1:0]   = poll_q;
        status[16]            = strobe_q;
        status[23:20]         = idx_q[0];
        status[27:24]         = idx_q[1];
    end

    always_comb begin
        reg_mux = '0;
        case (slave_address)
            ADDR_BUTTONS: reg_mux = {16'h0000, buttons_q};
            ADDR_CONTROL: reg_mux = {31'h0, enable_q};
            ADDR_STATUS:  reg_mux = status;
            ADDR_ID:      reg_mux = ID_VALUE;
            default:      reg_mux = '0;
        endcase
    end

    always_comb begin
        buttons_d = wr_buttons ? slave_writedata[15:0] : buttons_q;
        enable_d  = wr_control ? slave_writedata[0] : enable_q;
        strobe_d  = nes_strobe_we ? nes_strobe_d : strobe_q;
        rdata_d   = slave_read ? reg_mux : rdata_q;

        // clear has priority over a same-cycle strobe fall
        poll_d = poll_q;
        if (wr_control && slave_writedata[1]) begin
            poll_d = '0;
        end else if (strobe_fall) begin
            poll_d = poll_q + COUNT_W'(1);
        end
    end

    always_comb begin
        shift_d  = shift_q;
        idx_d    = idx_q;
        nes_rd_d = nes_rd_q;
        for (int i = 0; i < 2; i++) begin
            if (nes_rd_en[i]) begin
                // while strobe is held the pad reports the live A button
                nes_rd_d[i] = (strobe_q ? buttons_q[8*i] : shift_q[i][0]) & enable_q;
            end
            if (reload) begin
                shift_d[i] = buttons_q[8*i +: 8];
                idx_d[i]   = 4'd0;
            end else if (nes_rd_en[i]) begin
                shift_d[i] = {FILL_BIT, shift_q[i][7:1]};
                idx_d[i]   = idx_inc(idx_q[i]);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            buttons_q <= '0;
            enable_q  <= 1'b0;
            strobe_q  <= 1'b0;
            shift_q   <= '0;
            idx_q     <= '0;
            poll_q    <= '0;
            rdata_q   <= '0;
            nes_rd_q  <= '0;
        end else begin
            buttons_q <= buttons_d;
            enable_q  <= enable_d;
            strobe_q  <= strobe_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            poll_q    <= poll_d;
            rdata_q   <= rdata_d;
            nes_rd_q  <= nes_rd_d;
        end
    end

    assign slave_readdata = rdata_q;
    assign nes_rd_data    = nes_rd_q;

endmodule
